pc_ra_stack: RTL and testbench

- Program-counter register plus hardware return-address stack for the 16-bit accumulator processor.
- Sits directly downstream of the PC-select mux and loads its 16-bit output as the next PC.
- Also feeds that mux's return-address input (select 1) with the top-of-stack value.
- Call instructions push PC+2; return instructions pop.

---
 rtl/pc_ra_stack.sv | 94 +++++++++
 tb/tb_pc_ra_stack.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pc_ra_stack.sv
// Program counter plus circular hardware return-address stack.
// Calls push pc_out+PC_INC, returns pop; push+pop replaces the top entry.
module pc_ra_stack #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      PC_INC   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_we,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] ra_out,
  output logic             ra_empty,
  output logic             ra_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty_c, full_c;

  assign empty_c = (cnt_q == CNT_W'(0));
  assign full_c  = (cnt_q == CNT_W'(DEPTH));

  assign pc_out    = pc_q;
  assign pc_plus   = pc_q + WIDTH'(PC_INC);
  assign ra_out    = empty_c ? '0 : mem_q[top_q];
  assign ra_empty  = empty_c;
  assign ra_full   = full_c;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // Next-state: PC load, stack push/pop/replace, sticky errors (set beats clear)
  always_comb begin
    pc_d  = pc_we ? next_pc : pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    ovf_d = ovf_q & ~err_clr;
    unf_d = unf_q & ~err_clr;
    if (push && (!pop || empty_c)) begin
      top_d        = top_q + PTR_W'(1);
      mem_d[top_d] = pc_plus;
      if (full_c) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (push && pop) begin
      mem_d[top_q] = pc_plus;
    end else if (pop) begin
      if (empty_c) begin
        unf_d = 1'b1;
      end else begin
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_pc_ra_stack.sv
// Directed self-checking bench for pc_ra_stack with hand-computed expectations.
module tb_pc_ra_stack;

  logic        clk = 1'b0;
  logic        rst_n, pc_we, push, pop, err_clr;
  logic [15:0] next_pc;
  logic [15:0] pc_out, pc_plus, ra_out;
  logic        ra_empty, ra_full, overflow, underflow;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pc_ra_stack dut (
    .clk(clk), .rst_n(rst_n), .pc_we(pc_we), .next_pc(next_pc),
    .push(push), .pop(pop), .err_clr(err_clr),
    .pc_out(pc_out), .pc_plus(pc_plus), .ra_out(ra_out),
    .ra_empty(ra_empty), .ra_full(ra_full),
    .overflow(overflow), .underflow(underflow)
  );

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_we = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); next_pc = 16'h1234;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc[%0d]: got %h want 0000", i, pc_out); end
      checks++; if (pc_plus !== 16'h0002) begin errors++; $display("FAIL reset_pcplus[%0d]: got %h want 0002", i, pc_plus); end
      checks++; if (ra_out !== 16'h0000) begin errors++; $display("FAIL reset_ra[%0d]: got %h want 0000", i, ra_out); end
      checks++; if ({ra_empty, ra_full, overflow, underflow} !== 4'b1000) begin
        errors++; $display("FAIL reset_flags[%0d]: got %b want 1000", i, {ra_empty, ra_full, overflow, underflow});
      end
      step();
    end
  endtask

  task automatic test_call_return();
    pc_we = 1'b1; next_pc = 16'h0010; step();
    checks++; if (pc_out !== 16'h0010) begin errors++; $display("FAIL cr_load: got %h want 0010", pc_out); end
    push = 1'b1; next_pc = 16'h0100; step();
    push = 1'b0;
    checks++; if (pc_out !== 16'h0100) begin errors++; $display("FAIL cr_call_pc: got %h want 0100", pc_out); end
    checks++; if (ra_out !== 16'h0012) begin errors++; $display("FAIL cr_call_ra: got %h want 0012", ra_out); end
    checks++; if ({ra_empty, ra_full} !== 2'b00) begin errors++; $display("FAIL cr_call_cnt: got %b want 00", {ra_empty, ra_full}); end
    pop = 1'b1; next_pc = 16'h0012; step();
    idle();
    checks++; if (pc_out !== 16'h0012) begin errors++; $display("FAIL cr_ret_pc: got %h want 0012", pc_out); end
    checks++; if (ra_empty !== 1'b1) begin errors++; $display("FAIL cr_ret_empty: got %b want 1", ra_empty); end
  endtask

  task automatic test_fill_overflow();
    logic [15:0] pop_exp [4];
    pop_exp[0] = 16'h0008; pop_exp[1] = 16'h0006; pop_exp[2] = 16'h0004; pop_exp[3] = 16'h0000;
    pc_we = 1'b1; next_pc = 16'h0000; step();
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; pc_we = 1'b1; next_pc = 16'((i + 1) * 2); step();
      if (i == 3) begin
        checks++; if (ra_full !== 1'b1) begin errors++; $display("FAIL fill_full4: got %b want 1", ra_full); end
        checks++; if (ra_out !== 16'h0008) begin errors++; $display("FAIL fill_ra4: got %h want 0008", ra_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf4: got %b want 0", overflow); end
      end
    end
    idle();
    checks++; if (ra_out !== 16'h000A) begin errors++; $display("FAIL fill_ra5: got %h want 000a", ra_out); end
    checks++; if ({ra_full, overflow} !== 2'b11) begin errors++; $display("FAIL fill_ovf5: got %b want 11", {ra_full, overflow}); end
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1; step();
      checks++; if (ra_out !== pop_exp[i]) begin errors++; $display("FAIL fill_pop[%0d]: got %h want %h", i, ra_out, pop_exp[i]); end
    end
    pop = 1'b0;
    checks++; if ({ra_empty, overflow, underflow} !== 3'b110) begin
      errors++; $display("FAIL fill_end: got %b want 110", {ra_empty, overflow, underflow});
    end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_clr: got %b want 0", overflow); end
  endtask

  task automatic test_underflow();
    pop = 1'b1; step();
    checks++; if ({underflow, ra_empty} !== 2'b11) begin errors++; $display("FAIL unf_set: got %b want 11", {underflow, ra_empty}); end
    checks++; if (pc_out !== 16'h000A) begin errors++; $display("FAIL unf_pc: got %h want 000a", pc_out); end
    err_clr = 1'b1; step();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_setwins: got %b want 1", underflow); end
    pop = 1'b0; step(); err_clr = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr: got %b want 0", underflow); end
  endtask

  task automatic test_back_to_back();
    pc_we = 1'b1; next_pc = 16'h0010; step();
    push = 1'b1; next_pc = 16'h0200; step();
    pc_we = 1'b0; pop = 1'b1; step();
    checks++; if (ra_out !== 16'h0202) begin errors++; $display("FAIL pp_ra: got %h want 0202", ra_out); end
    checks++; if ({ra_empty, ra_full, overflow, underflow} !== 4'b0000) begin
      errors++; $display("FAIL pp_flags: got %b want 0000", {ra_empty, ra_full, overflow, underflow});
    end
    push = 1'b0; step();
    checks++; if (ra_empty !== 1'b1) begin errors++; $display("FAIL pp_count1: got %b want 1", ra_empty); end
    push = 1'b1; step();
    idle();
    checks++; if (ra_out !== 16'h0202) begin errors++; $display("FAIL pp_empty_ra: got %h want 0202", ra_out); end
    checks++; if ({ra_empty, underflow} !== 2'b00) begin errors++; $display("FAIL pp_empty_flags: got %b want 00", {ra_empty, underflow}); end
    pop = 1'b1; step(); pop = 1'b0;
    checks++; if (ra_empty !== 1'b1) begin errors++; $display("FAIL pp_empty_count: got %b want 1", ra_empty); end
  endtask

  task automatic test_wrap_reset();
    pc_we = 1'b1; next_pc = 16'hFFFE; step();
    pc_we = 1'b0;
    checks++; if (pc_plus !== 16'h0000) begin errors++; $display("FAIL wrap_pcplus: got %h want 0000", pc_plus); end
    push = 1'b1; step(); step(); step();
    checks++; if (ra_out !== 16'h0000 || ra_empty !== 1'b0) begin
      errors++; $display("FAIL wrap_push: got ra %h empty %b want 0000/0", ra_out, ra_empty);
    end
    pop = 1'b0; push = 1'b0; pc_we = 1'b1; next_pc = 16'h0040; step();
    pc_we = 1'b0; pop = 1'b1; step(); step(); step(); step(); pop = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL wrap_unf: got %b want 1", underflow); end
    push = 1'b1; step(); step(); step();
    checks++; if (ra_out !== 16'h0042) begin errors++; $display("FAIL wrap_3deep: got %h want 0042", ra_out); end
    rst_n = 1'b0; pc_we = 1'b1; next_pc = 16'h0300; step();
    rst_n = 1'b1; idle();
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL rst_mid_pc: got %h want 0000", pc_out); end
    checks++; if ({ra_empty, ra_full, overflow, underflow} !== 4'b1000) begin
      errors++; $display("FAIL rst_mid_flags: got %b want 1000", {ra_empty, ra_full, overflow, underflow});
    end
    checks++; if (ra_out !== 16'h0000) begin errors++; $display("FAIL rst_mid_ra: got %h want 0000", ra_out); end
    push = 1'b1; pop = 1'b1; step(); idle();
    checks++; if (ra_out !== 16'h0002) begin errors++; $display("FAIL rst_mid_after: got %h want 0002", ra_out); end
  endtask

  initial begin
    rst_n = 1'b0; idle(); next_pc = '0;
    #1;
    test_reset();
    test_call_return();
    test_fill_overflow();
    test_underflow();
    test_back_to_back();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
